sfx_note_sequencer: RTL and testbench

- Note-table responder for the sound-effect timing FSM, which issues `nextNoteLaser`/`nextNoteDeath` and `done`.
- Holds the laser and death note tables and presents the current note's duration code to the FSM.
- Advances a note pointer on each next-note pulse and flags end-of-effect on `SFXended`.
- Generates the square-wave speaker output for the current note's pitch. Sits between the sound control register bits and the speaker pin.

---
 rtl/sfx_note_sequencer_pkg.sv | 28 ++
 rtl/sfx_note_rom.sv | 62 ++++++
 rtl/sfx_note_sequencer.sv | 137 +++++++++++++
 tb/tb_sfx_note_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sfx_note_sequencer_pkg.sv
// Shared constants for the sound-effect note sequencer: duration codes,
// effect-select encodings, FSM states and the table entry width.
package sfx_pkg;

  localparam int DUR_W = 3;

  localparam logic [DUR_W-1:0] DUR_END       = 3'd0;
  localparam logic [DUR_W-1:0] DUR_QUARTER   = 3'd1;
  localparam logic [DUR_W-1:0] DUR_EIGHTH    = 3'd2;
  localparam logic [DUR_W-1:0] DUR_THIRD     = 3'd3;
  localparam logic [DUR_W-1:0] DUR_SIXTEENTH = 3'd4;
  localparam logic [DUR_W-1:0] DUR_SIXTH     = 3'd5;

  localparam logic [1:0] SFX_NONE  = 2'b00;
  localparam logic [1:0] SFX_DEATH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_END  = 2'd2
  } state_e;

  // Table entry is {dur, half_period}.
  function automatic int entry_w(input int div_w);
    return DUR_W + div_w;
  endfunction

endpackage

// File: rtl/sfx_note_rom.sv
// Fixed laser and death note tables, read combinationally by pointer.
// Entries past the table end read as the end marker.
module sfx_note_rom
  import sfx_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int PTR_W = 5
) (
  input  logic [PTR_W-1:0] lptr,
  input  logic [PTR_W-1:0] dptr,
  output logic [DUR_W-1:0] laser_dur,
  output logic [DIV_W-1:0] laser_hp,
  output logic [DUR_W-1:0] death_dur,
  output logic [DIV_W-1:0] death_hp
);

  localparam int EW = entry_w(DIV_W);

  logic [EW-1:0] laser_e;
  logic [EW-1:0] death_e;

  always_comb begin
    laser_e = {DUR_END, DIV_W'(0)};
    case (int'(lptr))
      0:       laser_e = {DUR_QUARTER,   DIV_W'(100)};
      1:       laser_e = {DUR_EIGHTH,    DIV_W'(80)};
      2:       laser_e = {DUR_SIXTEENTH, DIV_W'(60)};
      3:       laser_e = {DUR_THIRD,     DIV_W'(50)};
      4:       laser_e = {DUR_SIXTH,     DIV_W'(40)};
      5:       laser_e = {DUR_SIXTEENTH, DIV_W'(30)};
      6:       laser_e = {DUR_EIGHTH,    DIV_W'(20)};
      default: laser_e = {DUR_END,       DIV_W'(0)};
    endcase
  end

  // Entry 5 is a rest (half_period 0).
  always_comb begin
    death_e = {DUR_END, DIV_W'(0)};
    case (int'(dptr))
      0:       death_e = {DUR_QUARTER,   DIV_W'(200)};
      1:       death_e = {DUR_EIGHTH,    DIV_W'(220)};
      2:       death_e = {DUR_THIRD,     DIV_W'(240)};
      3:       death_e = {DUR_SIXTEENTH, DIV_W'(260)};
      4:       death_e = {DUR_SIXTH,     DIV_W'(280)};
      5:       death_e = {DUR_EIGHTH,    DIV_W'(0)};
      6:       death_e = {DUR_QUARTER,   DIV_W'(300)};
      7:       death_e = {DUR_EIGHTH,    DIV_W'(320)};
      8:       death_e = {DUR_THIRD,     DIV_W'(340)};
      9:       death_e = {DUR_SIXTEENTH, DIV_W'(360)};
      10:      death_e = {DUR_SIXTH,     DIV_W'(380)};
      11:      death_e = {DUR_QUARTER,   DIV_W'(400)};
      12:      death_e = {DUR_EIGHTH,    DIV_W'(420)};
      13:      death_e = {DUR_THIRD,     DIV_W'(440)};
      14:      death_e = {DUR_SIXTEENTH, DIV_W'(460)};
      default: death_e = {DUR_END,       DIV_W'(0)};
    endcase
  end

  assign {laser_dur, laser_hp} = laser_e;
  assign {death_dur, death_hp} = death_e;

endmodule

// File: rtl/sfx_note_sequencer.sv
// Note pointer FSM and square-wave tone generator answering the SFX timing FSM.
// Durations follow the registered pointers combinationally; outputs read 0 in IDLE.
module sfx_note_sequencer
  import sfx_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int PTR_W     = 5,
  parameter int LASER_LEN = 8,
  parameter int DEATH_LEN = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] soundRegBits,
  input  logic       nextNoteLaser,
  input  logic       nextNoteDeath,
  input  logic       done,
  output logic [2:0] durationLaser,
  output logic [2:0] durationDeath,
  output logic       SFXended,
  output logic       speaker,
  output logic       active
);

  localparam logic [PTR_W-1:0] LLAST = PTR_W'(LASER_LEN - 1);
  localparam logic [PTR_W-1:0] DLAST = PTR_W'(DEATH_LEN - 1);

  state_e             state_q, state_d;
  logic               sel_death_q, sel_death_d;
  logic [PTR_W-1:0]   lptr_q, lptr_d;
  logic [PTR_W-1:0]   dptr_q, dptr_d;
  logic [DIV_W-1:0]   tcnt_q, tcnt_d;
  logic               speaker_q, speaker_d;
  logic               sfx_ended_q, sfx_ended_d;
  logic               done_seen_q, done_seen_d;

  logic [DUR_W-1:0]   laser_dur, death_dur, sel_dur;
  logic [DIV_W-1:0]   laser_hp, death_hp, sel_hp;
  logic               sel_pulse, sel_at_last, advance;

  sfx_note_rom #(
    .DIV_W (DIV_W),
    .PTR_W (PTR_W)
  ) u_rom (
    .lptr      (lptr_q),
    .dptr      (dptr_q),
    .laser_dur (laser_dur),
    .laser_hp  (laser_hp),
    .death_dur (death_dur),
    .death_hp  (death_hp)
  );

  assign sel_dur     = sel_death_q ? death_dur : laser_dur;
  assign sel_hp      = sel_death_q ? death_hp : laser_hp;
  assign sel_pulse   = sel_death_q ? nextNoteDeath : nextNoteLaser;
  assign sel_at_last = sel_death_q ? (dptr_q == DLAST) : (lptr_q == LLAST);

  always_comb begin
    state_d     = state_q;
    sel_death_d = sel_death_q;
    lptr_d      = lptr_q;
    dptr_d      = dptr_q;
    done_seen_d = done_seen_q;
    advance     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        lptr_d      = '0;
        dptr_d      = '0;
        done_seen_d = 1'b0;
        if (soundRegBits != SFX_NONE) begin
          state_d     = ST_PLAY;
          sel_death_d = (soundRegBits == SFX_DEATH);
        end
      end
      ST_PLAY: begin
        // Abort wins over end detection; a marker entry freezes the pointer.
        if (soundRegBits == SFX_NONE) begin
          state_d = ST_IDLE;
        end else if (sel_dur == DUR_END) begin
          state_d = ST_END;
        end else if (sel_pulse && !sel_at_last) begin
          advance = 1'b1;
          if (sel_death_q) dptr_d = dptr_q + 1'b1;
          else             lptr_d = lptr_q + 1'b1;
        end
      end
      ST_END: begin
        if (done) done_seen_d = 1'b1;
        if ((done_seen_q || done) && (soundRegBits == SFX_NONE)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    sfx_ended_d = (state_q == ST_END) && (state_d == ST_END);

    // Tone runs only while staying in PLAY on the same note; a rest holds low.
    tcnt_d    = '0;
    speaker_d = 1'b0;
    if ((state_q == ST_PLAY) && (state_d == ST_PLAY) && !advance && (sel_hp != '0)) begin
      if (tcnt_q == sel_hp - DIV_W'(1)) begin
        speaker_d = ~speaker_q;
      end else begin
        tcnt_d    = tcnt_q + DIV_W'(1);
        speaker_d = speaker_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      sel_death_q <= 1'b0;
      lptr_q      <= '0;
      dptr_q      <= '0;
      tcnt_q      <= '0;
      speaker_q   <= 1'b0;
      sfx_ended_q <= 1'b0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_death_q <= sel_death_d;
      lptr_q      <= lptr_d;
      dptr_q      <= dptr_d;
      tcnt_q      <= tcnt_d;
      speaker_q   <= speaker_d;
      sfx_ended_q <= sfx_ended_d;
      done_seen_q <= done_seen_d;
    end
  end

  assign active        = (state_q != ST_IDLE);
  assign speaker       = speaker_q;
  assign SFXended      = sfx_ended_q;
  assign durationLaser = active ? laser_dur : DUR_END;
  assign durationDeath = active ? death_dur : DUR_END;

endmodule

// File: tb/tb_sfx_note_sequencer.sv
// Directed bench for sfx_note_sequencer: playback, end marker, crosstalk, abort,
// saturation and clear, with hand-computed expectations from the note tables.
module tb_sfx_note_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [1:0] soundRegBits = 2'b00;
  logic       nextNoteLaser = 1'b0;
  logic       nextNoteDeath = 1'b0;
  logic       done = 1'b0;
  logic [2:0] durationLaser;
  logic [2:0] durationDeath;
  logic       SFXended;
  logic       speaker;
  logic       active;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sfx_note_sequencer #(
    .DIV_W     (16),
    .PTR_W     (5),
    .LASER_LEN (8),
    .DEATH_LEN (16)
  ) dut (
    .clk           (clk),
    .clr           (clr),
    .soundRegBits  (soundRegBits),
    .nextNoteLaser (nextNoteLaser),
    .nextNoteDeath (nextNoteDeath),
    .done          (done),
    .durationLaser (durationLaser),
    .durationDeath (durationDeath),
    .SFXended      (SFXended),
    .speaker       (speaker),
    .active        (active)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_laser();
    nextNoteLaser = 1'b1;
    step(1);
    nextNoteLaser = 1'b0;
  endtask

  task automatic pulse_death();
    nextNoteDeath = 1'b1;
    step(1);
    nextNoteDeath = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    step(2);
    total++;
    if ({durationLaser, durationDeath, SFXended, speaker, active} !== 9'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {durationLaser, durationDeath, SFXended, speaker, active});
    end
    clr = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      total++;
      if (active !== 1'b0 || speaker !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet cycle=%0d active=%b speaker=%b want 0/0", i, active, speaker);
      end
    end
  endtask

  task automatic test_laser_play();
    soundRegBits = 2'b01;
    step(1);
    total++;
    if (durationLaser !== 3'd1 || active !== 1'b1 || speaker !== 1'b0) begin
      bad++;
      $display("FAIL laser_entry0 dur=%0d active=%b speaker=%b want 1/1/0", durationLaser, active, speaker);
    end
    step(99);
    total++;
    if (speaker !== 1'b0) begin bad++; $display("FAIL laser_low_c100 got=%b want=0", speaker); end
    step(1);
    total++;
    if (speaker !== 1'b1) begin bad++; $display("FAIL laser_high_c101 got=%b want=1", speaker); end
    step(49);
    total++;
    if (speaker !== 1'b1) begin bad++; $display("FAIL laser_high_c150 got=%b want=1", speaker); end
    pulse_laser();
    total++;
    if (durationLaser !== 3'd2 || speaker !== 1'b0) begin
      bad++;
      $display("FAIL laser_entry1 dur=%0d speaker=%b want 2/0", durationLaser, speaker);
    end
    step(79);
    total++;
    if (speaker !== 1'b0) begin bad++; $display("FAIL entry1_low_80 got=%b want=0", speaker); end
    step(1);
    total++;
    if (speaker !== 1'b1) begin bad++; $display("FAIL entry1_high_81 got=%b want=1", speaker); end
  endtask

  task automatic test_end_of_effect();
    for (int i = 0; i < 6; i++) pulse_laser();
    total++;
    if (durationLaser !== 3'd0 || dut.lptr_q !== 5'd7) begin
      bad++;
      $display("FAIL marker_reached dur=%0d lptr=%0d want 0/7", durationLaser, dut.lptr_q);
    end
    step(2);
    total++;
    if (SFXended !== 1'b1 || active !== 1'b1 || speaker !== 1'b0) begin
      bad++;
      $display("FAIL sfx_ended ended=%b active=%b speaker=%b want 1/1/0", SFXended, active, speaker);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
    step(3);
    total++;
    if (SFXended !== 1'b1 || active !== 1'b1) begin
      bad++;
      $display("FAIL ended_held ended=%b active=%b want 1/1", SFXended, active);
    end
    soundRegBits = 2'b00;
    step(1);
    total++;
    if (SFXended !== 1'b0 || active !== 1'b0) begin
      bad++;
      $display("FAIL end_exit ended=%b active=%b want 0/0", SFXended, active);
    end
    step(1);
    total++;
    if (dut.lptr_q !== 5'd0 || dut.dptr_q !== 5'd0) begin
      bad++;
      $display("FAIL end_ptr_clear lptr=%0d dptr=%0d want 0/0", dut.lptr_q, dut.dptr_q);
    end
  endtask

  task automatic test_death_crosstalk();
    soundRegBits = 2'b11;
    step(1);
    total++;
    if (durationDeath !== 3'd1 || active !== 1'b1) begin
      bad++;
      $display("FAIL death_entry0 dur=%0d active=%b want 1/1", durationDeath, active);
    end
    for (int i = 0; i < 3; i++) pulse_laser();
    total++;
    if (durationDeath !== 3'd1 || dut.dptr_q !== 5'd0 || dut.lptr_q !== 5'd0) begin
      bad++;
      $display("FAIL laser_ignored ddur=%0d dptr=%0d lptr=%0d want 1/0/0", durationDeath, dut.dptr_q, dut.lptr_q);
    end
    pulse_death();
    total++;
    if (durationDeath !== 3'd2) begin bad++; $display("FAIL death_entry1 got=%0d want=2", durationDeath); end
    nextNoteLaser = 1'b1;
    pulse_death();
    nextNoteLaser = 1'b0;
    total++;
    if (durationDeath !== 3'd3 || dut.lptr_q !== 5'd0) begin
      bad++;
      $display("FAIL both_pulses ddur=%0d lptr=%0d want 3/0", durationDeath, dut.lptr_q);
    end
    soundRegBits = 2'b01;
    pulse_death();
    total++;
    if (durationDeath !== 3'd4 || active !== 1'b1) begin
      bad++;
      $display("FAIL sel_latched ddur=%0d active=%b want 4/1", durationDeath, active);
    end
  endtask

  task automatic test_abort();
    step(260);
    total++;
    if (speaker !== 1'b1) begin bad++; $display("FAIL death3_high got=%b want=1", speaker); end
    soundRegBits = 2'b00;
    step(1);
    total++;
    if (active !== 1'b0 || speaker !== 1'b0 || dut.dptr_q !== 5'd3) begin
      bad++;
      $display("FAIL abort_idle active=%b speaker=%b dptr=%0d want 0/0/3", active, speaker, dut.dptr_q);
    end
    step(1);
    total++;
    if (dut.dptr_q !== 5'd0) begin bad++; $display("FAIL abort_ptr_clear got=%0d want=0", dut.dptr_q); end
    soundRegBits = 2'b01;
    step(1);
    total++;
    if (durationLaser !== 3'd1 || active !== 1'b1) begin
      bad++;
      $display("FAIL rerequest dur=%0d active=%b want 1/1", durationLaser, active);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 7; i++) pulse_laser();
    nextNoteLaser = 1'b1;
    step(3);
    nextNoteLaser = 1'b0;
    total++;
    if (dut.lptr_q !== 5'd7 || durationLaser !== 3'd0 || SFXended !== 1'b1) begin
      bad++;
      $display("FAIL saturate lptr=%0d dur=%0d ended=%b want 7/0/1", dut.lptr_q, durationLaser, SFXended);
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    total++;
    if ({durationLaser, durationDeath, SFXended, speaker, active} !== 9'd0) begin
      bad++;
      $display("FAIL clr_in_end got=%b want=0", {durationLaser, durationDeath, SFXended, speaker, active});
    end
  endtask

  task automatic test_rest_and_clear();
    soundRegBits = 2'b11;
    step(1);
    for (int i = 0; i < 5; i++) pulse_death();
    step(300);
    total++;
    if (durationDeath !== 3'd2 || speaker !== 1'b0 || active !== 1'b1) begin
      bad++;
      $display("FAIL rest_note ddur=%0d speaker=%b active=%b want 2/0/1", durationDeath, speaker, active);
    end
    clr = 1'b1;
    step(1);
    total++;
    if ({durationLaser, durationDeath, SFXended, speaker, active} !== 9'd0 || dut.dptr_q !== 5'd0) begin
      bad++;
      $display("FAIL clr_in_play out=%b dptr=%0d want 0/0", {durationLaser, durationDeath, SFXended, speaker, active}, dut.dptr_q);
    end
    clr = 1'b0;
    soundRegBits = 2'b00;
    step(2);
  endtask

  initial begin
    test_reset();
    test_laser_play();
    test_end_of_effect();
    test_death_crosstalk();
    test_abort();
    test_saturation();
    test_rest_and_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
